// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: next-PC input, instruction-memory port and decode handshake.
// The master modport belongs to pc_fetch and the slave modport to its environment.
interface pc_fetch_if;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic        fault;
   logic [1:0]  fault_cause;

   modport master (
      input  npc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, pc, inst, inst_valid, fault, fault_cause
   );

   modport slave (
      output npc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, pc, inst, inst_valid, fault, fault_cause
   );
endinterface

// File: rtl/pc_fetch.sv
// Architectural PC holder and single-outstanding instruction fetcher.
// Fetches from variable-latency imem, presents to decode, and faults on timeout or misaligned npc.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   pc_fetch_if.master       bus,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StReq, StHold, StFault} state_e;

   state_e           state_q;
   logic [31:0]      pc_q;
   logic [31:0]      inst_q;
   logic             req_q;
   logic             valid_q;
   logic             fault_q;
   logic [1:0]       cause_q;
   logic [CNT_W-1:0] ret_q;
   logic [TW-1:0]    tmo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StReq;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= 2'b00;
         ret_q   <= '0;
         tmo_q   <= '0;
      end else begin
         case (state_q)
            StReq: begin
               // req is low only on the first cycle out of reset
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (bus.imem_ack) begin
                  inst_q  <= bus.imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= StHold;
               end else if (tmo_q == TMO_LAST) begin
                  fault_q <= 1'b1;
                  cause_q <= 2'b10;
                  req_q   <= 1'b0;
                  state_q <= StFault;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            StHold: begin
               if (bus.inst_ready) begin
                  valid_q <= 1'b0;
                  if (|bus.npc[1:0]) begin
                     fault_q <= 1'b1;
                     cause_q <= 2'b01;
                     state_q <= StFault;
                  end else begin
                     pc_q    <= bus.npc;
                     ret_q   <= ret_q + CNT_W'(1);
                     tmo_q   <= '0;
                     req_q   <= 1'b1;
                     state_q <= StReq;
                  end
               end
            end
            StFault: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
            default: state_q <= StFault;
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.pc          = pc_q;
   assign bus.inst        = inst_q;
   assign bus.inst_valid  = valid_q;
   assign bus.fault       = fault_q;
   assign bus.fault_cause = cause_q;
   assign retired         = ret_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized traffic, each cycle compared
// against a transaction-level reference model of the fetch rules.
module tb_pc_fetch;
   localparam int unsigned CW  = 4;
   localparam int unsigned TMO = 16;
   localparam logic [31:0] RPC = 32'h0000_3000;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] retired;

   pc_fetch_if bus ();

   pc_fetch #(
      .RESET_PC(RPC),
      .TIMEOUT (TMO),
      .CNT_W   (CW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .retired(retired)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: what the outside world should see
   logic [31:0] m_pc, m_inst;
   logic        m_req, m_valid, m_fault;
   logic [1:0]  m_cause;
   logic [CW-1:0] m_ret;
   int          m_wait;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check("pc", bus.pc, m_pc);
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
      check("imem_addr", bus.imem_addr, m_pc);
      check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
      if (m_valid) check("inst", bus.inst, m_inst);
      check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
      check("fault_cause", {30'd0, bus.fault_cause}, {30'd0, m_cause});
      check("retired", {28'd0, retired}, {28'd0, m_ret});
   endtask

   // Applied at each rising edge with the inputs that were presented during the cycle.
   task automatic model_edge();
      if (rst) begin
         m_pc = RPC; m_inst = '0; m_req = 0; m_valid = 0;
         m_fault = 0; m_cause = 0; m_ret = '0; m_wait = 0;
      end else if (m_fault) begin
         // frozen until reset
      end else if (m_valid) begin
         if (bus.inst_ready) begin
            m_valid = 0;
            if (bus.npc[1:0] != 2'b00) begin
               m_fault = 1; m_cause = 2'b01;
            end else begin
               m_pc = bus.npc; m_ret = m_ret + 1'b1; m_wait = 0; m_req = 1;
            end
         end
      end else if (!m_req) begin
         m_req = 1;
      end else if (bus.imem_ack) begin
         m_inst = bus.imem_rdata; m_valid = 1; m_req = 0;
      end else if (m_wait == TMO - 1) begin
         m_fault = 1; m_cause = 2'b10; m_req = 0;
      end else begin
         m_wait++;
      end
   endtask

   task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                      input logic rdy, input logic [31:0] n);
      rst = r; bus.imem_ack = a; bus.imem_rdata = d; bus.inst_ready = rdy; bus.npc = n;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   logic [31:0] ref_inst;
   logic [31:0] nxt;
   int          ack_pct;

   initial begin
      rst = 1; bus.imem_ack = 0; bus.imem_rdata = '0; bus.inst_ready = 0; bus.npc = '0;
      m_wait = 0;

      // T1 reset
      repeat (3) cyc(1, 0, 32'h0, 0, 32'h0);
      check("t1_pc", bus.pc, RPC);
      check("t1_req", {31'd0, bus.imem_req}, 32'd0);
      check("t1_ret", {28'd0, retired}, 32'd0);
      cyc(0, 0, 32'h0, 0, 32'h0);
      check("t1_req_rise", {31'd0, bus.imem_req}, 32'd1);
      check("t1_addr", bus.imem_addr, 32'h0000_3000);

      // T2 zero-wait fetch
      cyc(0, 1, 32'h2008_0005, 1, 32'h0000_3004);
      check("t2_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("t2_inst", bus.inst, 32'h2008_0005);
      cyc(0, 0, 32'h0, 1, 32'h0000_3004);
      check("t2_addr", bus.imem_addr, 32'h0000_3004);
      check("t2_ret", {28'd0, retired}, 32'd1);

      // T3 backpressure then jump
      cyc(0, 1, 32'h1234_5678, 0, 32'h0040_0000);
      repeat (4) begin
         cyc(0, 0, 32'h0, 0, 32'h0040_0000);
         check("t3_hold_inst", bus.inst, 32'h1234_5678);
         check("t3_no_req", {31'd0, bus.imem_req}, 32'd0);
      end
      cyc(0, 0, 32'h0, 1, 32'h0040_0000);
      check("t3_jump_pc", bus.pc, 32'h0040_0000);

      // T4 slow memory then timeout
      repeat (5) begin
         cyc(0, 0, 32'h0, 0, 32'h0);
         check("t4_addr_stable", bus.imem_addr, 32'h0040_0000);
      end
      cyc(0, 1, 32'hcafe_0001, 0, 32'h0040_0004);
      check("t4_no_fault", {31'd0, bus.fault}, 32'd0);
      cyc(0, 0, 32'h0, 1, 32'h0040_0004);
      repeat (15) cyc(0, 0, 32'h0, 0, 32'h0);
      check("t4_edge_no_fault", {31'd0, bus.fault}, 32'd0);
      cyc(0, 0, 32'h0, 0, 32'h0);
      check("t4_fault", {31'd0, bus.fault}, 32'd1);
      check("t4_cause", {30'd0, bus.fault_cause}, 32'd2);
      check("t4_req", {31'd0, bus.imem_req}, 32'd0);

      // T5 misaligned npc
      repeat (2) cyc(1, 0, 32'h0, 0, 32'h0);
      cyc(0, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 32'h0000_0013, 0, 32'h0);
      cyc(0, 0, 32'h0, 1, 32'h0000_3006);
      check("t5_cause", {30'd0, bus.fault_cause}, 32'd1);
      check("t5_pc", bus.pc, 32'h0000_3000);
      check("t5_ret", {28'd0, retired}, 32'd0);
      cyc(1, 0, 32'h0, 0, 32'h0);
      check("t5_recover_pc", bus.pc, 32'h0000_3000);
      check("t5_recover_fault", {31'd0, bus.fault}, 32'd0);

      // T6 counter wrap and reset mid-request
      cyc(0, 0, 32'h0, 0, 32'h0);
      nxt = 32'h0000_3000;
      for (int i = 0; i < 17; i++) begin
         nxt = nxt + 32'd4;
         cyc(0, 1, $urandom, 0, 32'h0);
         cyc(0, 0, 32'h0, 1, nxt);
      end
      check("t6_wrap", {28'd0, retired}, 32'd1);
      check("t6_req_busy", {31'd0, bus.imem_req}, 32'd1);
      cyc(1, 0, 32'h0, 0, 32'h0);
      cyc(0, 1, 32'hdead_beef, 0, 32'h0);
      check("t6_late_ack", {31'd0, bus.inst_valid}, 32'd0);

      // Randomized traffic
      ack_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         logic r, a, rdy;
         logic [31:0] n;
         if (i % 250 == 0) begin
            case ($urandom_range(0, 3))
               0: ack_pct = 90;
               1: ack_pct = 50;
               2: ack_pct = 15;
               default: ack_pct = 3;
            endcase
         end
         r   = m_fault ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
         a   = $urandom_range(0, 99) < ack_pct;
         rdy = $urandom_range(0, 9) < 7;
         case ($urandom_range(0, 19))
            0:       n = $urandom | 32'd1;
            1, 2:    n = m_pc;
            default: n = $urandom & 32'hffff_fffc;
         endcase
         cyc(r, a, $urandom, rdy, n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
